// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU op codes.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } mdop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that run through the pending register and the latency counter.
    function automatic logic is_long_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
// MDU_MADD_EN adds the accumulate/subtract forms against the current {hi,lo}.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] hilo;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_s;
    logic [31:0] div_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign hilo   = {hi, lo};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_mag  = a[31] ? -a : a;
    assign b_mag  = b[31] ? -b : b;
    assign div_s  = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / div_s;
    assign r_mag  = a_mag % div_s;
    assign quot_s = (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign rem_s  = a[31] ? -r_mag : r_mag;

    assign div_u  = (b == 32'd0) ? 32'd1 : b;
    assign quot_u = a / div_u;
    assign rem_u  = a % div_u;

    always_comb begin
        result = hilo;
        case (mdop)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = (b == 32'd0) ? hilo : {rem_s, quot_s};
            MD_DIVU:  result = (b == 32'd0) ? hilo : {rem_u, quot_u};
`ifdef MDU_MADD_EN
            MD_MADD:  result = hilo + prod_s;
            MD_MADDU: result = hilo + prod_u;
            MD_MSUB:  result = hilo - prod_s;
            MD_MSUBU: result = hilo - prod_u;
`endif
            default:  result = hilo;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MD sequencer: latches the result, holds busy for a fixed latency, then commits HI/LO.
// MDU_MADD_EN enables the MADD-class op codes (latency MULT_CYCLES).
//
// state   | meaning
// IDLE    | HI/LO valid; accepts MD ops, MTHI/MTLO write directly
// BUSY    | result pending; counter runs down, commit when it reaches 1
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ph_q, ph_d;
    logic [31:0] pl_q, pl_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic [63:0] res;

    mdu_arith u_arith (
        .mdop   (mdop),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !req) begin
                    if (is_long_op(mdop)) begin
                        ph_d    = res[63:32];
                        pl_d    = res[31:0];
                        cnt_d   = is_div_op(mdop) ? DIV_LD : MULT_LD;
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end else if (mdop == MD_MTHI) begin
                        hi_d = a;
                    end else if (mdop == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                // req no longer matters here: the op has left E and must commit.
                if (cnt_q == 4'd1) begin
                    hi_d    = ph_q;
                    lo_d    = pl_q;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ph_q    <= 32'd0;
            pl_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected commits are queued at issue, a monitor checks them when busy drops.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .a     (a),
        .b     (b),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic rq);
        @(posedge clk); #1;
        start = 1'b1; mdop = op; a = av; b = bv; req = rq;
        @(posedge clk); #1;
        start = 1'b0; mdop = 4'd0; req = 1'b0;
    endtask

    task automatic push(input logic [31:0] eh, input logic [31:0] el, input int ec);
        exp_t e;
        e.hi = eh; e.lo = el; e.cyc = ec;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=busy_%0b/pending_%0d required=idle", nm, busy, exp_q.size());
        end
    endtask

    // Monitor: measures busy length and checks HI/LO in the first cycle busy is low.
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_commit actual=busy_for_%0d required=no_busy", cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_len", 64'(cnt), 64'(e.cyc));
                        chk("commit_hi", {32'd0, hi}, {32'd0, e.hi});
                        chk("commit_lo", {32'd0, lo}, {32'd0, e.lo});
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && busy && start) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_while_busy actual=start_1 required=start_0");
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; mdop = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle("mult");

        push(32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle("multu");

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle("div");

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        wait_idle("divu_by_zero");

        push(32'h0000_0000, 32'h8000_0000, 10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle("div_overflow");

        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, busy}, 64'd0);

        issue(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("mtlo_req_lo", {32'd0, lo}, 64'h8000_0000);

        issue(4'd1, 32'd5, 32'd7, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("mult_req_busy", {63'd0, busy}, 64'd0);
        chk("mult_req_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

        push(32'd0, 32'd35, 5);
        issue(4'd1, 32'd5, 32'd7, 1'b0);
        @(posedge clk); #1;
        req = 1'b1;
        chk("hold_during_busy", {hi, lo}, 64'h1234_5678_8000_0000);
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle("mult_req_mid");

        push(32'd2, 32'd14, 10);
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        wait_idle("divu");

        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("madd_setup", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`ifdef MDU_MADD_EN
        push(32'd1, 32'd0, 5);
        issue(4'd8, 32'd1, 32'd1, 1'b0);
        wait_idle("maddu");
`else
        issue(4'd8, 32'd1, 32'd1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("maddu_off_busy", {63'd0, busy}, 64'd0);
        chk("maddu_off_hilo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        issue(4'd1, 32'd2, 32'd3, 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", {63'd0, busy}, 64'd0);
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_commit_after_reset_busy", {63'd0, busy}, 64'd0);
        chk("no_commit_after_reset_hilo", {hi, lo}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
